// File: rtl/shift_ctrl_pkg.sv
// Shared encodings for the shift-register command sequencer: operations,
// register modes and sequencer states.
package shift_ctrl_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SHR   = 2'b01;
  localparam logic [1:0] OP_SHL   = 2'b10;
  localparam logic [1:0] OP_ROTR  = 2'b11;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/shift_cnt.sv
// Loadable down counter; 'last' flags the final cycle of a command (count == 1).
module shift_cnt #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          last
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == ONE);

endmodule

// File: rtl/shift_reg_ctrl.sv
// Command sequencer for a universal shift register: accepts one command over
// a valid/ready handshake, holds the register mode for the commanded cycles,
// then pulses done.
module shift_reg_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [N-1:0]  cmd_data,
  input  logic [CW-1:0] cmd_count,
  input  logic          cmd_fill,
  input  logic [N-1:0]  q_in,
  output logic [1:0]    sel,
  output logic [N-1:0]  I,
  output logic          MSB,
  output logic          LSB,
  output logic          busy,
  output logic          done,
  output logic          dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high exactly when the FSM is idle,
  // and the requester must hold cmd_valid and the command fields until then.

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    op_q, op_d;
  logic [N-1:0]  i_q, i_d;
  logic          msb_q, msb_d;
  logic          lsb_q, lsb_d;
  logic          done_q, done_d;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_last;
  logic          q_unused;

  // Only the LSB of the register is needed, to close the rotate loop.
  assign q_unused = ^q_in[N-1:1];

  shift_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (state_q == ST_RUN),
    .last     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    op_d     = op_q;
    i_d      = i_q;
    msb_d    = msb_q;
    lsb_d    = lsb_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = cmd_count;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          if (cmd_op == OP_LOAD) begin
            sel_d    = SEL_LOAD;
            i_d      = cmd_data;
            cnt_val  = ONE;
            cnt_load = 1'b1;
            state_d  = ST_RUN;
          end else if (cmd_count == '0) begin
            // Zero-length shift: nothing for the register to do.
            done_d = 1'b1;
          end else begin
            cnt_load = 1'b1;
            state_d  = ST_RUN;
            case (cmd_op)
              OP_SHR: begin
                sel_d = SEL_SHR;
                msb_d = cmd_fill;
              end
              OP_SHL: begin
                sel_d = SEL_SHL;
                lsb_d = cmd_fill;
              end
              default: sel_d = SEL_SHR;
            endcase
          end
        end
      end
      ST_RUN: begin
        // Remember the last rotate feedback bit so MSB holds it once idle.
        if (op_q == OP_ROTR) begin
          msb_d = q_in[0];
        end
        if (cnt_last) begin
          sel_d   = SEL_HOLD;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SEL_HOLD;
      op_q    <= OP_LOAD;
      i_q     <= '0;
      msb_q   <= 1'b0;
      lsb_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      i_q     <= i_d;
      msb_q   <= msb_d;
      lsb_q   <= lsb_d;
      done_q  <= done_d;
    end
  end

  assign sel       = sel_q;
  assign I         = i_q;
  assign LSB       = lsb_q;
  assign MSB       = ((state_q == ST_RUN) && (op_q == OP_ROTR)) ? q_in[0] : msb_q;
  assign busy      = (state_q == ST_RUN);
  assign cmd_ready = (state_q == ST_IDLE);
  assign done      = done_q;
  assign dbg_state = (state_q == ST_RUN);

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// System-level bench: shift_reg_ctrl driving a universal shift register whose
// Q feeds back to q_in, checked against hand-computed command vectors.
module tb_shift_reg_ctrl;

  localparam int N  = 4;
  localparam int CW = 3;

  logic          clk;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [N-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
  logic          cmd_fill;
  logic [N-1:0]  q_reg;
  logic [1:0]    sel;
  logic [N-1:0]  I;
  logic          MSB;
  logic          LSB;
  logic          busy;
  logic          done;
  logic          dbg_state;

  int n_chk  = 0;
  int n_fail = 0;

  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [1:0]    op;
    logic [N-1:0]  data;
    logic [CW-1:0] count;
    logic          fill;
    logic [1:0]    exp_sel;
    int            exp_len;
    logic [31:0]   seq;     // Q after each shift, first shift in the low nibble
    logic [N-1:0]  q_end;
  } vec_t;

  vec_t vecs[11];

  shift_reg_ctrl #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .cmd_fill  (cmd_fill),
    .q_in      (q_reg),
    .sel       (sel),
    .I         (I),
    .MSB       (MSB),
    .LSB       (LSB),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset block and the universal shift register being sequenced.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_reg <= '0;
    end else begin
      case (sel)
        2'b01:   q_reg <= {MSB, q_reg[N-1:1]};
        2'b10:   q_reg <= {q_reg[N-2:0], LSB};
        2'b11:   q_reg <= I;
        default: q_reg <= q_reg;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: issue one command at the current negedge and follow it to done.
  task automatic run_vec(input vec_t v);
    int  cyc;
    int  sel_cycles;
    bit  got_done;
    cmd_op    = v.op;
    cmd_data  = v.data;
    cmd_count = v.count;
    cmd_fill  = v.fill;
    cmd_valid = 1'b1;
    for (int j = 0; j < v.exp_len; j++) exp_q.push_back(v.seq[4*j +: 4]);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    sel_cycles = 0;
    got_done = 1'b0;
    while (!got_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc >= 2 && exp_q.size() > 0) chk("q_step", q_reg, exp_q.pop_front());
      if (cyc == 1 && v.op == 2'b00) chk("load_data", I, v.data);
      if (sel != 2'b00) begin
        sel_cycles++;
        chk("run_sel", sel, v.exp_sel);
        chk("run_busy", busy, 1'b1);
        if (v.op == 2'b11) chk("rotr_msb", MSB, q_reg[0]);
      end
      if (done) begin
        got_done = 1'b1;
        chk("done_sel", sel, 2'b00);
        chk("done_ready", cmd_ready, 1'b1);
      end
    end
    chk("done_seen", got_done, 1'b1);
    chk("sel_cycles", sel_cycles, v.exp_len);
    chk("q_end", q_reg, v.q_end);
    exp_q.delete();
  endtask

  initial begin
    //                op     data     cnt   fill sel    len seq           q_end
    vecs[0]  = '{2'b00, 4'b0101, 3'd0, 1'b0, 2'b11, 1, 32'h00000005, 4'h5};
    vecs[1]  = '{2'b01, 4'b0000, 3'd2, 1'b1, 2'b01, 2, 32'h000000DA, 4'hD};
    vecs[2]  = '{2'b10, 4'b0000, 3'd3, 1'b0, 2'b10, 3, 32'h0000084A, 4'h8};
    vecs[3]  = '{2'b00, 4'b0011, 3'd0, 1'b0, 2'b11, 1, 32'h00000003, 4'h3};
    vecs[4]  = '{2'b00, 4'b1011, 3'd0, 1'b0, 2'b11, 1, 32'h0000000B, 4'hB};
    vecs[5]  = '{2'b11, 4'b0000, 3'd4, 1'b0, 2'b01, 4, 32'h0000B7ED, 4'hB};
    vecs[6]  = '{2'b01, 4'b1111, 3'd0, 1'b1, 2'b00, 0, 32'h00000000, 4'hB};
    vecs[7]  = '{2'b10, 4'b0000, 3'd7, 1'b1, 2'b10, 7, 32'h0FFFFFF7, 4'hF};
    vecs[8]  = '{2'b00, 4'b1001, 3'd5, 1'b0, 2'b11, 1, 32'h00000009, 4'h9};
    vecs[9]  = '{2'b11, 4'b0000, 3'd1, 1'b0, 2'b01, 1, 32'h0000000C, 4'hC};
    vecs[10] = '{2'b01, 4'b0000, 3'd3, 1'b0, 2'b01, 3, 32'h00000136, 4'h1};

    // Reset with a command already presented: nothing may be accepted.
    reset_n   = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 4'b1111;
    cmd_count = 3'd3;
    cmd_fill  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel", sel, 2'b00);
    chk("rst_I", I, 4'h0);
    chk("rst_msb_lsb", {MSB, LSB}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_state", dbg_state, 1'b0);
    chk("rst_q", q_reg, 4'h0);
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    chk("idle_sel", sel, 2'b00);

    // Table-driven commands, each issued in the done cycle of the previous one.
    for (int k = 0; k < 11; k++) run_vec(vecs[k]);

    // Commands presented while busy are ignored.
    cmd_op = 2'b10; cmd_data = 4'b0000; cmd_count = 3'd3; cmd_fill = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_op = 2'b00;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("busy_ign_sel", sel, 2'b10);
      chk("busy_ign_ready", cmd_ready, 1'b0);
      if (c == 2) chk("busy_ign_q2", q_reg, 4'h3);
      if (c == 3) chk("busy_ign_q3", q_reg, 4'h7);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("busy_ign_done", done, 1'b1);
    chk("busy_ign_q4", q_reg, 4'hF);
    @(negedge clk);
    chk("done_width", done, 1'b0);
    chk("no_late_accept", sel, 2'b00);
    chk("q_kept", q_reg, 4'hF);

    // Reset mid-SHR with two shifts remaining.
    cmd_op = 2'b01; cmd_count = 3'd4; cmd_fill = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_sel", sel, 2'b01);
    @(negedge clk);
    chk("mid_q1", q_reg, 4'h7);
    @(negedge clk);
    chk("mid_q2", q_reg, 4'h3);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_sel", sel, 2'b00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", cmd_ready, 1'b1);
    chk("mid_rst_state", dbg_state, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_done", done, 1'b0);
      chk("post_rst_sel", sel, 2'b00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
